// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: plays an init ROM table to the LCD, then grants the LCD to CPU byte requests
module lcd_cmd_sequencer #(
  parameter int          ADDR_W      = 6,
  parameter int unsigned DELAY_UNIT  = 100000,
  parameter int unsigned ACK_TIMEOUT = 1000000
) (
  input  logic              CLK_100MHz,
  input  logic              RESET,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [9:0]        rom_data,
  input  logic              cpu_load,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_is_cmd,
  output logic              cpu_accept,
  output logic              cpu_ready,
  output logic              lcd_load,
  output logic [7:0]        lcd_data,
  output logic              lcd_is_cmd,
  input  logic              lcd_busy,
  input  logic              lcd_ready,
  output logic              init_done,
  output logic              init_error
);
  typedef enum logic [2:0] {WAIT_RDY, FETCH, WAIT_ACK, WAIT_DONE, DELAY, RUN, ERROR} state_t;
  state_t state, stateN;
  logic [ADDR_W-1:0] addrN;
  logic [7:0] dataN;
  logic [31:0] dlyCnt, dlyCntN, toCnt, toCntN;
  logic isCmdN, loadN, doneN, errN, acceptN, cpuSrc, cpuSrcN, pend, pendN, adv, req;
  wire idle = lcd_ready && !lcd_busy;
  wire lastEntry = &rom_addr;
  assign cpu_ready = state == RUN;
  assign req = start || pend;
  // State and output registers; async reset drops lcd_load immediately
  always_ff @(posedge CLK_100MHz or posedge RESET) begin
    if (RESET) begin
      state <= WAIT_RDY;
      rom_addr <= '0;
      lcd_data <= '0;
      lcd_is_cmd <= 1'b0;
      lcd_load <= 1'b0;
      init_done <= 1'b0;
      init_error <= 1'b0;
      cpu_accept <= 1'b0;
      cpuSrc <= 1'b0;
      pend <= 1'b0;
      dlyCnt <= '0;
      toCnt <= '0;
    end else begin
      state <= stateN;
      rom_addr <= addrN;
      lcd_data <= dataN;
      lcd_is_cmd <= isCmdN;
      lcd_load <= loadN;
      init_done <= doneN;
      init_error <= errN;
      cpu_accept <= acceptN;
      cpuSrc <= cpuSrcN;
      pend <= pendN;
      dlyCnt <= dlyCntN;
      toCnt <= toCntN;
    end
  end
  // Next-state logic; start is deferred while a byte is in flight and overrides everything else
  always_comb begin
    stateN = state;
    addrN = rom_addr;
    dataN = lcd_data;
    isCmdN = lcd_is_cmd;
    loadN = lcd_load;
    doneN = init_done;
    errN = init_error;
    acceptN = 1'b0;
    cpuSrcN = cpuSrc;
    pendN = pend;
    dlyCntN = dlyCnt;
    toCntN = toCnt;
    adv = 1'b0;
    case (state)
      WAIT_RDY: stateN = idle ? FETCH : WAIT_RDY;
      FETCH: begin
        case (rom_data[9:8])
          2'b10: begin
            adv = rom_data[7:0] == 8'd0;
            dlyCntN = 32'(rom_data[7:0]) * DELAY_UNIT;
            stateN = adv ? FETCH : DELAY;
          end
          2'b11: begin
            doneN = 1'b1;
            stateN = RUN;
          end
          default: begin
            dataN = rom_data[7:0];
            isCmdN = ~rom_data[8];
            loadN = 1'b1;
            cpuSrcN = 1'b0;
            stateN = WAIT_ACK;
          end
        endcase
      end
      WAIT_ACK: begin
        pendN = req;
        if (lcd_busy) begin
          loadN = 1'b0;
          toCntN = '0;
          stateN = WAIT_DONE;
        end else if (toCnt == ACK_TIMEOUT - 1) begin
          loadN = 1'b0;
          errN = 1'b1;
          dataN = '0;
          isCmdN = 1'b0;
          toCntN = '0;
          stateN = ERROR;
        end else toCntN = toCnt + 1;
      end
      WAIT_DONE: begin
        pendN = req;
        stateN = idle && cpuSrc ? RUN : WAIT_DONE;
        adv = idle && !cpuSrc;
      end
      DELAY: begin
        adv = dlyCnt == 0;
        dlyCntN = adv ? dlyCnt : dlyCnt - 1;
      end
      RUN: begin
        if (cpu_load && idle) begin
          dataN = cpu_data;
          isCmdN = cpu_is_cmd;
          loadN = 1'b1;
          acceptN = 1'b1;
          cpuSrcN = 1'b1;
          stateN = WAIT_ACK;
        end
      end
      default: ;
    endcase
    if (adv) begin
      if (lastEntry) begin
        doneN = 1'b1;
        stateN = RUN;
      end else begin
        addrN = rom_addr + 1'b1;
        stateN = FETCH;
      end
    end
    if (req && (state == WAIT_DONE ? idle : state != WAIT_ACK)) begin
      stateN = WAIT_RDY;
      addrN = '0;
      doneN = 1'b0;
      errN = 1'b0;
      pendN = 1'b0;
      acceptN = 1'b0;
      loadN = 1'b0;
      dlyCntN = '0;
    end
  end
endmodule

// File: doc/lcd_cmd_sequencer.md
Name: lcd_cmd_sequencer

Overview:
Sequences the LCD driver's byte interface (load/data_in/is_cmd, busy/ready) for two sources. After reset or a start pulse it plays a power-up table from an external init ROM, including timed delays. It then grants the LCD to the CPU-side MMIO path, one byte per handshake. It sits between the memory-mapped IO decoder and the LCD module and owns the complete load/busy handshake.

Parameters:
ADDR_W, 6, init ROM address width (max 64 entries)
DELAY_UNIT, 100000, clock cycles per delay tick (1 ms at 100 MHz)
ACK_TIMEOUT, 1000000, max cycles to wait for lcd_busy rise after lcd_load asserts

Ports:
CLK_100MHz  in  1  system clock
RESET  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: re-run init table from entry 0
rom_addr  out  ADDR_W  init ROM address
rom_data  in  10  ROM entry, valid combinationally for current rom_addr; [9:8] type (00 cmd, 01 data, 10 delay, 11 end), [7:0] payload
cpu_load  in  1  CPU byte request, level, held until cpu_accept
cpu_data  in  8  CPU byte
cpu_is_cmd  in  1  1=command byte, 0=data byte
cpu_accept  out  1  one-cycle pulse: CPU byte handed to LCD
cpu_ready  out  1  init done, no transfer in flight, no error
lcd_load  out  1  to LCD load
lcd_data  out  8  to LCD data_in
lcd_is_cmd  out  1  to LCD is_cmd
lcd_busy  in  1  from LCD busy
lcd_ready  in  1  from LCD ready
init_done  out  1  high once the end entry is reached; cleared by start/RESET
init_error  out  1  sticky ack timeout flag; cleared by start/RESET

Behaviour:
- Reset (async, any state): state=WAIT_RDY; rom_addr=0; all outputs 0; delay/timeout counters 0. lcd_load drops with RESET, without waiting for a clock.
- WAIT_RDY: stay until lcd_ready=1 and lcd_busy=0, then go to FETCH.
- FETCH: decode rom_data.
  - cmd/data: latch lcd_data=payload, lcd_is_cmd=(type==00), lcd_load=1, go to WAIT_ACK.
  - delay: load counter=payload*DELAY_UNIT (32-bit), go to DELAY. payload 0 = no wait, rom_addr+1 next cycle.
  - end: init_done=1, go to RUN.
  - rom_addr == 2^ADDR_W-1 and entry is not end: execute the entry, then treat as end. No wrap to 0.
- WAIT_ACK: lcd_load held at 1. The first cycle with lcd_busy=1 sets lcd_load=0 and goes to WAIT_DONE. The timeout counter increments each cycle. At ACK_TIMEOUT: lcd_load=0, init_error=1, go to ERROR.
- WAIT_DONE: wait for lcd_busy=0 and lcd_ready=1.
  - Init source: rom_addr+1, go to FETCH.
  - CPU source: go to RUN.
- DELAY: decrement each cycle; at 0, rom_addr+1, go to FETCH.
- RUN: cpu_ready=1. If cpu_load=1 and lcd_ready=1 and lcd_busy=0: latch cpu_data/cpu_is_cmd, lcd_load=1, cpu_accept=1 for that one cycle, cpu_ready=0, go to WAIT_ACK (CPU source).
- ERROR: all LCD outputs 0, cpu_ready=0. Only start or RESET exits.
- Arbitration: init has absolute priority. cpu_load during init is not accepted and not lost; the CPU holds it until cpu_accept. Maximum one byte in flight.
- start:
  - In RUN, WAIT_RDY, DELAY or ERROR: clear init_done and init_error, rom_addr=0, go to WAIT_RDY next cycle.
  - In WAIT_ACK or WAIT_DONE: record it as pending and act on it after the current byte completes. The byte is never aborted.
  - start coincident with cpu_load in RUN: start wins, cpu_accept stays 0.
- Latency: FETCH of cmd/data to lcd_load=1 is 1 cycle. cpu_load seen in RUN to lcd_load=1 and cpu_accept is 1 cycle.

Test Plan:
- Table {cmd 0x01, delay 2, data 0xAB, end} with DELAY_UNIT=10 and an LCD model acking after 3 cycles, busy for 5 cycles -> lcd_data 0x01 (is_cmd=1), gap ≥20 cycles, then 0xAB (is_cmd=0); init_done=1; cpu_ready=1.
- After init, cpu_load with 0x2C cmd -> cpu_accept single pulse, lcd_load=1 until first busy cycle, lcd_is_cmd=1; cpu_ready returns after busy falls.
- cpu_load held from reset through init -> no cpu_accept before init_done; byte accepted 1 cycle after RUN is entered; exactly one pulse.
- LCD model never asserts busy, ACK_TIMEOUT=50 -> lcd_load drops at cycle 50, init_error=1, cpu_ready=0; start then replays the table from entry 0 with init_error cleared.
- RESET asserted mid-WAIT_ACK -> lcd_load=0 immediately (asynchronously); after release, the sequence restarts at rom_addr=0.
- ADDR_W=2 table {cmd,cmd,cmd,cmd} without end -> 4 bytes sent, init_done=1, rom_addr stays 3.
